// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline-stage buffer:
//   - pipe_state_e : occupancy state of one stage (empty / one entry / two entries)
//   - PIPE_*       : default widths used when a stage is instantiated without
//                    overrides
//   - CTRL_*       : bit positions inside the control bundle carried next to the
//                    payload (decode/execute control flags)
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Occupancy of a stage: main register only, or main plus skid register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Default geometry of a stage.
  localparam int unsigned PIPE_DATA_W = 96;
  localparam int unsigned PIPE_CTRL_W = 7;
  localparam int unsigned PIPE_SKID   = 1;
  localparam int unsigned PIPE_CNT_W  = 16;

  // Control-bundle bit positions.
  localparam int unsigned CTRL_SAVE_TO_REG    = 0;
  localparam int unsigned CTRL_RS1_USED       = 1;
  localparam int unsigned CTRL_RS2_USED       = 2;
  localparam int unsigned CTRL_IMMEDIATE_USED = 3;
  localparam int unsigned CTRL_IS_BRANCH      = 4;
  localparam int unsigned CTRL_RD_MEMORY      = 5;
  localparam int unsigned CTRL_WR_MEMORY      = 6;

endpackage

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
// Saturating up-counter used for stage performance statistics.
// The count sticks at all-ones instead of wrapping; a clear request wins over
// an increment in the same cycle.
// Ports:
//   clk_i  in   1      clock, rising edge
//   rst_i  in   1      asynchronous active-high reset (count -> 0)
//   inc_i  in   1      count this cycle
//   clr_i  in   1      synchronous clear, overrides inc_i
//   cnt_o  out  CNT_W  current (registered) count
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then saturating increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer
// Valid/ready pipeline-stage register carrying an opaque payload and a control
// bundle between two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// SKID=1: main register plus a one-entry skid register. in_ready is a flop
//         (= "skid register is free"), so it never depends on out_ready
//         within the same cycle and the ready path is cut at every stage.
// SKID=0: single register, in_ready = !out_valid | out_ready (combinational),
//         which still streams one entry per cycle.
//
// flush kills every held entry and drops the entry offered in that cycle.
// out_ctrl is forced to zero while out_valid is low so a bubble can never
// trigger a register write or memory access downstream.
//
// Ports:
//   stg_clk     in   1       stage clock, rising edge
//   reset       in   1       asynchronous active-high reset
//   in_valid    in   1       upstream offers an entry
//   in_ready    out  1       stage can accept an entry
//   in_data     in   DATA_W  upstream payload
//   in_ctrl     in   CTRL_W  upstream control bits
//   out_valid   out  1       stage presents an entry
//   out_ready   in   1       downstream accepts
//   out_data    out  DATA_W  head-entry payload (holds when invalid)
//   out_ctrl    out  CTRL_W  head-entry control bits, 0 when invalid
//   flush       in   1       synchronous kill of all held entries
//   clr_cnt     in   1       synchronous clear of both counters
//   stall_cnt   out  CNT_W   cycles with out_valid & !out_ready (saturating)
//   bubble_cnt  out  CNT_W   cycles with !out_valid & out_ready (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned SKID   = PIPE_SKID,
  parameter int unsigned CNT_W  = PIPE_CNT_W
) (
  input  logic              stg_clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_d;
  // With SKID=1 this is the registered in_ready itself; with SKID=0 it only
  // marks "out of reset for at least one edge" and gates the combinational
  // ready so that in_ready stays low until the first edge after reset.
  logic              in_ready_q;
  logic              in_ready_d;

  logic              in_ready_s;
  logic              accept_s;
  logic              deliver_s;
  logic              stall_inc_s;
  logic              bubble_inc_s;

  assign in_ready_s = (SKID != 0) ? in_ready_q
                                  : (in_ready_q & (~valid_q | out_ready));
  assign accept_s   = in_valid & in_ready_s;
  assign deliver_s  = valid_q & out_ready;

  // Occupancy and datapath next-state; flush overrides accept and deliver.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (deliver_s && accept_s) begin
            // Head leaves while the next entry arrives: reload in place.
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (deliver_s) begin
            state_d = ST_EMPTY;
          end else if (accept_s) begin
            // Only reachable with SKID=1; the SKID=0 ready blocks this case.
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the head can move.
          if (deliver_s) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign valid_d    = (state_d != ST_EMPTY);
  assign in_ready_d = (SKID != 0) ? (state_d != ST_TWO) : 1'b1;

  // Stage state registers; reset discards every entry and closes in_ready.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      valid_q     <= 1'b0;
      main_data_q <= {DATA_W{1'b0}};
      main_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{valid_q}};

  // Performance counters observe the output handshake only; flush is ignored.
  assign stall_inc_s  = valid_q & ~out_ready;
  assign bubble_inc_s = ~valid_q & out_ready;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (stg_clk),
    .rst_i (reset),
    .inc_i (stall_inc_s),
    .clr_i (clr_cnt),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk_i (stg_clk),
    .rst_i (reset),
    .inc_i (bubble_inc_s),
    .clr_i (clr_cnt),
    .cnt_o (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buffer
// Directed bench for pipe_stage_buffer. Instance "a" uses SKID=1 with 4-bit
// counters; instance "b" uses SKID=0 with default 16-bit counters.
// Inputs change 1 time unit after a rising edge; registered outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buffer;

  logic        stg_clk = 1'b0;
  logic        reset   = 1'b1;

  logic        a_in_valid = 1'b0, a_out_ready = 1'b0, a_flush = 1'b0, a_clr_cnt = 1'b0;
  logic [95:0] a_in_data  = 96'h0;
  logic [6:0]  a_in_ctrl  = 7'h0;
  logic        a_in_ready, a_out_valid;
  logic [95:0] a_out_data;
  logic [6:0]  a_out_ctrl;
  logic [3:0]  a_stall, a_bubble;

  logic        b_in_valid = 1'b0, b_out_ready = 1'b0, b_flush = 1'b0, b_clr_cnt = 1'b0;
  logic [95:0] b_in_data  = 96'h0;
  logic [6:0]  b_in_ctrl  = 7'h0;
  logic        b_in_ready, b_out_valid;
  logic [95:0] b_out_data;
  logic [6:0]  b_out_ctrl;
  logic [15:0] b_stall, b_bubble;

  int total = 0;
  int bad   = 0;

  always #5 stg_clk = ~stg_clk;

  pipe_stage_buffer #(.SKID(1), .CNT_W(4)) dut_a (
    .stg_clk(stg_clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .flush(a_flush), .clr_cnt(a_clr_cnt), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  pipe_stage_buffer #(.SKID(0)) dut_b (
    .stg_clk(stg_clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .flush(b_flush), .clr_cnt(b_clr_cnt), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
  );

  task automatic step();
    @(posedge stg_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_a_out_valid: got %0h want 0", a_out_valid); end
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_a_in_ready: got %0h want 0", a_in_ready); end
    total++; if (a_out_ctrl !== 7'h0) begin bad++; $display("FAIL rst_a_out_ctrl: got %0h want 0", a_out_ctrl); end
    total++; if (a_out_data !== 96'h0) begin bad++; $display("FAIL rst_a_out_data: got %0h want 0", a_out_data); end
    total++; if (a_stall !== 4'h0 || a_bubble !== 4'h0) begin bad++; $display("FAIL rst_a_cnt: got %0h/%0h want 0/0", a_stall, a_bubble); end
    total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL rst_b_in_ready: got %0h want 0", b_in_ready); end
    reset = 1'b0;
    #1;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rel_a_in_ready_pre_edge: got %0h want 0", a_in_ready); end
    step();
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rel_a_in_ready: got %0h want 1", a_in_ready); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL rel_b_in_ready: got %0h want 1", b_in_ready); end
  endtask

  task automatic test_single();
    a_in_valid = 1'b1; a_in_data = 96'h1234; a_in_ctrl = 7'h41; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0h want 1", a_out_valid); end
    total++; if (a_out_data !== 96'h1234) begin bad++; $display("FAIL single_data: got %0h want 1234", a_out_data); end
    total++; if (a_out_ctrl !== 7'h41) begin bad++; $display("FAIL single_ctrl: got %0h want 41", a_out_ctrl); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %0h want 1", a_in_ready); end
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid: got %0h want 0", a_out_valid); end
    total++; if (a_out_ctrl !== 7'h0) begin bad++; $display("FAIL single_drain_ctrl: got %0h want 0", a_out_ctrl); end
    total++; if (a_out_data !== 96'h1234) begin bad++; $display("FAIL single_data_hold: got %0h want 1234", a_out_data); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL single_drain_in_ready: got %0h want 1", a_in_ready); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    a_in_valid = 1'b1; a_in_data = 96'h1; a_in_ctrl = 7'h01;
    step();
    total++; if (a_out_data !== 96'h1 || a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_A_loaded: got data=%0h rdy=%0h want 1/1", a_out_data, a_in_ready); end
    a_in_data = 96'h2; a_in_ctrl = 7'h02;
    step();
    a_in_valid = 1'b0;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready: got %0h want 0", a_in_ready); end
    total++; if (a_out_data !== 96'h1 || a_out_ctrl !== 7'h01) begin bad++; $display("FAIL bp_head_A: got %0h/%0h want 1/1", a_out_data, a_out_ctrl); end
    a_out_ready = 1'b1;
    step();
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 96'h2 || a_out_ctrl !== 7'h02) begin bad++; $display("FAIL bp_head_B: got v=%0h d=%0h c=%0h want 1/2/2", a_out_valid, a_out_data, a_out_ctrl); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_after_A: got %0h want 1", a_in_ready); end
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %0h want 0", a_out_valid); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_flush();
    a_in_valid = 1'b1; a_in_data = 96'h4; a_in_ctrl = 7'h7f;
    step();
    a_in_data = 96'h5;
    step();
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL flush_two_held: got %0h want 0", a_in_ready); end
    a_flush = 1'b1; a_in_data = 96'h3;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0h want 0", a_out_valid); end
    total++; if (a_out_ctrl !== 7'h0) begin bad++; $display("FAIL flush_ctrl: got %0h want 0", a_out_ctrl); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %0h want 1", a_in_ready); end
    // Flush in ONE with an acceptable offer: the offer must be dropped.
    a_in_valid = 1'b1; a_in_data = 96'h6; a_in_ctrl = 7'h11;
    step();
    total++; if (a_out_data !== 96'h6 || a_out_valid !== 1'b1) begin bad++; $display("FAIL flush_F_loaded: got %0h/%0h want 6/1", a_out_data, a_out_valid); end
    a_flush = 1'b1; a_in_data = 96'h7;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    step(); step(); step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost: got %0h want 0", a_out_valid); end
    total++; if (a_out_data !== 96'h6) begin bad++; $display("FAIL flush_dropped_offer: got %0h want 6", a_out_data); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_stream_skid0();
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1; b_in_data = 96'(i); b_in_ctrl = 7'(i + 1);
      #1;
      total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready_%0d: got %0h want 1", i, b_in_ready); end
      step();
      total++; if (b_out_valid !== 1'b1 || b_out_data !== 96'(i) || b_out_ctrl !== 7'(i + 1)) begin bad++; $display("FAIL stream_out_%0d: got v=%0h d=%0h c=%0h want 1/%0h/%0h", i, b_out_valid, b_out_data, b_out_ctrl, i, i + 1); end
    end
    b_in_valid = 1'b0;
    step();
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %0h want 0", b_out_valid); end
    total++; if (b_stall !== 16'd0) begin bad++; $display("FAIL stream_stall_cnt: got %0d want 0", b_stall); end
    total++; if (b_bubble !== 16'd1) begin bad++; $display("FAIL stream_bubble_cnt: got %0d want 1", b_bubble); end
    // Combinational ready under backpressure.
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 96'h20;
    step();
    b_in_data = 96'h21;
    #1;
    total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL skid0_bp_in_ready: got %0h want 0", b_in_ready); end
    step();
    total++; if (b_out_data !== 96'h20 || b_stall !== 16'd1) begin bad++; $display("FAIL skid0_hold: got d=%0h stall=%0d want 20/1", b_out_data, b_stall); end
    b_out_ready = 1'b1;
    #1;
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL skid0_comb_ready: got %0h want 1", b_in_ready); end
    step();
    total++; if (b_out_valid !== 1'b1 || b_out_data !== 96'h21) begin bad++; $display("FAIL skid0_reload: got v=%0h d=%0h want 1/21", b_out_valid, b_out_data); end
    b_in_valid = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    a_clr_cnt = 1'b1; a_in_valid = 1'b1; a_in_data = 96'h9; a_in_ctrl = 7'h15; a_out_ready = 1'b0;
    step();
    a_clr_cnt = 1'b0; a_in_valid = 1'b0;
    total++; if (a_stall !== 4'd0) begin bad++; $display("FAIL sat_clr_start: got %0d want 0", a_stall); end
    repeat (14) step();
    total++; if (a_stall !== 4'd14) begin bad++; $display("FAIL sat_count14: got %0d want 14", a_stall); end
    repeat (6) step();
    total++; if (a_stall !== 4'd15) begin bad++; $display("FAIL sat_count20: got %0d want 15", a_stall); end
    step();
    total++; if (a_stall !== 4'd15) begin bad++; $display("FAIL sat_stays: got %0d want 15", a_stall); end
    a_clr_cnt = 1'b1;
    step();
    a_clr_cnt = 1'b0;
    total++; if (a_stall !== 4'd0) begin bad++; $display("FAIL sat_clr: got %0d want 0", a_stall); end
    step();
    total++; if (a_stall !== 4'd1) begin bad++; $display("FAIL sat_restart: got %0d want 1", a_stall); end
  endtask

  task automatic test_async_reset();
    total++; if (a_out_ctrl !== 7'h15) begin bad++; $display("FAIL ar_ctrl_before: got %0h want 15", a_out_ctrl); end
    a_in_valid = 1'b1; a_in_data = 96'hA; a_in_ctrl = 7'h7f;
    step();
    a_in_valid = 1'b0;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL ar_two_held: got %0h want 0", a_in_ready); end
    #2 reset = 1'b1;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 7'h0) begin bad++; $display("FAIL ar_immediate_out: got v=%0h c=%0h want 0/0", a_out_valid, a_out_ctrl); end
    total++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin bad++; $display("FAIL ar_immediate_in_ready: got a=%0h b=%0h want 0/0", a_in_ready, b_in_ready); end
    total++; if (a_stall !== 4'd0) begin bad++; $display("FAIL ar_cnt: got %0d want 0", a_stall); end
    step();
    reset = 1'b0;
    #1;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL ar_release_pre_edge: got %0h want 0", a_in_ready); end
    step();
    total++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin bad++; $display("FAIL ar_release_in_ready: got a=%0h b=%0h want 1/1", a_in_ready, b_in_ready); end
    a_out_ready = 1'b1;
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL ar_discarded: got %0h want 0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_stream_skid0();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
